// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph plotter and the text-buffer controller.
// Glyph geometry, bus widths, the plotter state encoding and the
// pixel arithmetic helpers live here.
package glyph_pkg;

    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int GLYPH_BITS = 128;

    localparam int COL_W    = 5;
    localparam int ROW_W    = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;

    localparam int CNT_C_W = 3;
    localparam int CNT_R_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plotState_t;

    // Row 0 occupies the top byte and the MSB of each row is the leftmost
    // pixel, so pixel (r, c) is bit 127 - (r*8 + c).
    function automatic logic glyphBit(input logic [GLYPH_BITS-1:0] glyph,
                                      input logic [CNT_R_W-1:0] r,
                                      input logic [CNT_C_W-1:0] c);
        logic [CNT_R_W+CNT_C_W-1:0] bitIdx;
        bitIdx = 7'(GLYPH_BITS - 1) - {r, c};
        return glyph[bitIdx];
    endfunction

    function automatic logic [X_W-1:0] pixelX(input logic [COL_W-1:0] col,
                                              input logic [CNT_C_W-1:0] c);
        return X_W'(col) * X_W'(GLYPH_W) + X_W'(c);
    endfunction

    function automatic logic [Y_W-1:0] pixelY(input logic [ROW_W-1:0] row,
                                              input logic [CNT_R_W-1:0] r);
        return Y_W'(row) * Y_W'(GLYPH_H) + Y_W'(r);
    endfunction

endpackage

// File: rtl/glyph_plotter_if.sv
// Request and framebuffer-write bundle of the glyph plotter.
// The master side is the text-buffer/cursor logic (it also watches the
// pixel stream); the slave side is the plotter itself.
interface glyph_plotter_if;
    import glyph_pkg::*;

    logic                  start;
    logic [GLYPH_BITS-1:0] glyph;
    logic [COL_W-1:0]      char_col;
    logic [ROW_W-1:0]      char_row;
    logic [COLOUR_W-1:0]   fg_colour;
    logic [COLOUR_W-1:0]   bg_colour;

    logic [X_W-1:0]        x;
    logic [Y_W-1:0]        y;
    logic [COLOUR_W-1:0]   colour;
    logic                  plot;
    logic                  busy;
    logic                  done;

    modport master (
        output start, glyph, char_col, char_row, fg_colour, bg_colour,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, glyph, char_col, char_row, fg_colour, bg_colour,
        output x, y, colour, plot, busy, done
    );

endinterface

// File: rtl/glyph_scan_counter.sv
// Row-major pixel counter for one 8x16 glyph.
// The counter holds the pixel currently on the plotter outputs; the
// plotter reads the following pixel from cNext_o/rNext_o so that each
// registered pixel is ready on the same edge the counter advances.
module glyph_scan_counter
    import glyph_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               enable_i,
    output logic [CNT_C_W-1:0] cNext_o,
    output logic [CNT_R_W-1:0] rNext_o,
    output logic               last_o
);

    logic [CNT_C_W-1:0] c_q, c_d;
    logic [CNT_R_W-1:0] r_q, r_d;

    assign cNext_o = c_q + 3'd1;
    assign rNext_o = (c_q == 3'(GLYPH_W - 1)) ? r_q + 4'd1 : r_q;
    assign last_o  = (c_q == 3'(GLYPH_W - 1)) && (r_q == 4'(GLYPH_H - 1));

    // Clear wins over enable; enable steps c and carries into r on wrap.
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (clear_i) begin
            c_d = '0;
            r_d = '0;
        end else if (enable_i) begin
            c_d = cNext_o;
            r_d = rNext_o;
        end
    end

    // Counter state, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

endmodule

// File: rtl/glyph_plotter.sv
// Serialises one latched 8x16 glyph into 128 registered framebuffer
// writes, one per clock, then pulses done for a single cycle.
// Optional build macro GLYPH_PLOTTER_TRANSPARENT_EN: clear glyph bits
// suppress plot instead of being painted with bg_colour.
module glyph_plotter
    import glyph_pkg::*;
#(
    parameter int COLS = 20,
    parameter int ROWS = 7
) (
    input  logic            clk,
    input  logic            reset,
    glyph_plotter_if.slave  bus
);

    plotState_t            state_q;
    logic [GLYPH_BITS-1:0] glyph_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic [COLOUR_W-1:0]   fg_q;
    logic [COLOUR_W-1:0]   bg_q;

    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic [COLOUR_W-1:0]   colour_q;
    logic                  plot_q;
    logic                  busy_q;
    logic                  done_q;

    logic [CNT_C_W-1:0]    cNext;
    logic [CNT_R_W-1:0]    rNext;
    logic                  scanLast;
    logic                  scanClear;
    logic                  scanEnable;

    logic                  startInRange;
    logic                  startBit, nextBit;
    logic [COLOUR_W-1:0]   startColour, nextColour;
    logic                  startPlot, nextPlot;

    assign scanClear  = (state_q == IDLE) && bus.start;
    assign scanEnable = (state_q == DRAW) && !scanLast;

    glyph_scan_counter u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (scanClear),
        .enable_i (scanEnable),
        .cNext_o  (cNext),
        .rNext_o  (rNext),
        .last_o   (scanLast)
    );

    // Pixel 0 is formed straight from the request so it is on the outputs
    // the cycle after start; later pixels come from the latched request.
    always_comb begin
        startInRange = (int'(bus.char_col) < COLS) && (int'(bus.char_row) < ROWS);
        startBit     = glyphBit(bus.glyph, 4'd0, 3'd0);
        nextBit      = glyphBit(glyph_q, rNext, cNext);
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
        startColour  = bus.fg_colour;
        nextColour   = fg_q;
        startPlot    = startBit;
        nextPlot     = nextBit;
`else
        startColour  = startBit ? bus.fg_colour : bus.bg_colour;
        nextColour   = nextBit ? fg_q : bg_q;
        startPlot    = 1'b1;
        nextPlot     = 1'b1;
`endif
    end

    // Request FSM with registered pixel, busy and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            glyph_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        glyph_q <= bus.glyph;
                        col_q   <= bus.char_col;
                        row_q   <= bus.char_row;
                        fg_q    <= bus.fg_colour;
                        bg_q    <= bus.bg_colour;
                        busy_q  <= 1'b1;
                        if (startInRange) begin
                            state_q  <= DRAW;
                            x_q      <= pixelX(bus.char_col, 3'd0);
                            y_q      <= pixelY(bus.char_row, 4'd0);
                            colour_q <= startColour;
                            plot_q   <= startPlot;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (scanLast) begin
                        state_q <= DONE;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        x_q      <= pixelX(col_q, cNext);
                        y_q      <= pixelY(row_q, rNext);
                        colour_q <= nextColour;
                        plot_q   <= nextPlot;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    plot_q  <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_glyph_plotter.sv
// Self-checking bench for glyph_plotter. Requests are driven with
// randomised content and the pixel stream is compared with a
// coordinate/bitmap model of the glyph scan.
// Honours GLYPH_PLOTTER_TRANSPARENT_EN when the build defines it.
module tb_glyph_plotter;
    import glyph_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    logic [127:0] reqGlyph;
    int           reqCol, reqRow;
    logic [2:0]   reqFg, reqBg;

    logic       plotA   [0:255];
    logic       doneA   [0:255];
    logic       busyA   [0:255];
    logic [7:0] xA      [0:255];
    logic [6:0] yA      [0:255];
    logic [2:0] colourA [0:255];

    localparam logic [127:0] GLYPH_I =
        128'h003C_1818_1818_1818_183C_0000_0000_0000;

    glyph_plotter_if bus ();

    glyph_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: pixel k of the scan is column k%8, row k/8 of the cell.
    function automatic logic mBit(input int k);
        return reqGlyph[127 - k];
    endfunction

    function automatic int mX(input int k);
        return reqCol * 8 + (k % 8);
    endfunction

    function automatic int mY(input int k);
        return reqRow * 16 + (k / 8);
    endfunction

    function automatic logic mPlot(input int k);
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
        return mBit(k);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [2:0] mColour(input int k);
`ifdef GLYPH_PLOTTER_TRANSPARENT_EN
        return reqFg;
`else
        return mBit(k) ? reqFg : reqBg;
`endif
    endfunction

    function automatic int mPlotCount();
        int n = 0;
        for (int k = 0; k < 128; k++) if (mPlot(k)) n++;
        return n;
    endfunction

    // Presents a request with start high at the next falling edge.
    task automatic applyStimulus(input logic [127:0] g, input int col, input int row,
                                 input logic [2:0] fg, input logic [2:0] bg);
        @(negedge clk);
        bus.glyph     = g;
        bus.char_col  = 5'(col);
        bus.char_row  = 3'(row);
        bus.fg_colour = fg;
        bus.bg_colour = bg;
        bus.start     = 1'b1;
        reqGlyph = g; reqCol = col; reqRow = row; reqFg = fg; reqBg = bg;
    endtask

    // Records outputs for cycles 1..n after the request; scrambles the
    // request inputs after acceptance unless start is to be held.
    task automatic captureOutput(input int n, input bit hold);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            plotA[i] = bus.plot; doneA[i] = bus.done; busyA[i] = bus.busy;
            xA[i] = bus.x; yA[i] = bus.y; colourA[i] = bus.colour;
            if (!hold) begin
                bus.start     = 1'b0;
                bus.glyph     = {$urandom, $urandom, $urandom, $urandom};
                bus.char_col  = 5'($urandom);
                bus.char_row  = 3'($urandom);
                bus.fg_colour = 3'($urandom);
                bus.bg_colour = 3'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.glyph = '0; bus.char_col = '0; bus.char_row = '0;
        bus.fg_colour = '0; bus.bg_colour = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        assertCount++; if (bus.x !== 8'd0) begin failCount++; $display("[TB] FAIL reset_x: got %0d, required 0", bus.x); end
        assertCount++; if (bus.y !== 7'd0) begin failCount++; $display("[TB] FAIL reset_y: got %0d, required 0", bus.y); end
        assertCount++; if (bus.colour !== 3'd0) begin failCount++; $display("[TB] FAIL reset_colour: got %b, required 000", bus.colour); end
        assertCount++; if (bus.plot !== 1'b0) begin failCount++; $display("[TB] FAIL reset_plot: got %b, required 0", bus.plot); end
        assertCount++; if (bus.busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b, required 0", bus.busy); end
        assertCount++; if (bus.done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b, required 0", bus.done); end
    endtask

    task automatic test_blank();
        int busyN = 0;
        int plotN = 0;
        applyStimulus(128'd0, 0, 0, 3'b111, 3'b001);
        captureOutput(140, 1'b0);
        for (int k = 0; k < 128; k++) begin
            assertCount++;
            if (plotA[k+1] !== mPlot(k) || (mPlot(k) && (xA[k+1] !== 8'(mX(k)) ||
                yA[k+1] !== 7'(mY(k)) || colourA[k+1] !== mColour(k)))) begin
                failCount++;
                $display("[TB] FAIL blank_pixel %0d: got plot=%b x=%0d y=%0d colour=%b, required plot=%b x=%0d y=%0d colour=%b",
                         k, plotA[k+1], xA[k+1], yA[k+1], colourA[k+1], mPlot(k), mX(k), mY(k), mColour(k));
            end
        end
        for (int i = 1; i <= 140; i++) begin
            if (busyA[i] === 1'b1) busyN++;
            if (plotA[i] === 1'b1) plotN++;
        end
        assertCount++; if (plotN !== mPlotCount()) begin failCount++; $display("[TB] FAIL blank_plot_count: got %0d, required %0d", plotN, mPlotCount()); end
        assertCount++; if (doneA[129] !== 1'b1 || doneA[128] !== 1'b0 || doneA[130] !== 1'b0) begin
            failCount++; $display("[TB] FAIL blank_done_cycle: got done[128..130]=%b%b%b, required 010", doneA[128], doneA[129], doneA[130]);
        end
        assertCount++; if (busyN !== 129 || busyA[1] !== 1'b1) begin failCount++; $display("[TB] FAIL blank_busy: got %0d cycles, required 129 from cycle 1", busyN); end
    endtask

    task automatic test_glyph_i();
        int plotN = 0;
        applyStimulus(GLYPH_I, 19, 6, 3'b100, 3'b010);
        captureOutput(140, 1'b0);
        for (int k = 0; k < 128; k++) begin
            assertCount++;
            if (plotA[k+1] !== mPlot(k) || (mPlot(k) && (xA[k+1] !== 8'(mX(k)) ||
                yA[k+1] !== 7'(mY(k)) || colourA[k+1] !== mColour(k)))) begin
                failCount++;
                $display("[TB] FAIL glyph_i_pixel %0d: got plot=%b x=%0d y=%0d colour=%b, required plot=%b x=%0d y=%0d colour=%b",
                         k, plotA[k+1], xA[k+1], yA[k+1], colourA[k+1], mPlot(k), mX(k), mY(k), mColour(k));
            end
        end
        for (int i = 1; i <= 140; i++) if (plotA[i] === 1'b1) plotN++;
        assertCount++; if (plotA[11] !== 1'b1 || xA[11] !== 8'd154 || yA[11] !== 7'd97 || colourA[11] !== 3'b100) begin
            failCount++; $display("[TB] FAIL glyph_i_r1c2: got plot=%b (%0d,%0d) colour=%b, required plot=1 (154,97) colour=100", plotA[11], xA[11], yA[11], colourA[11]);
        end
        assertCount++; if (xA[1] !== 8'd152 || yA[1] !== 7'd96) begin failCount++; $display("[TB] FAIL glyph_i_first: got (%0d,%0d), required (152,96)", xA[1], yA[1]); end
        assertCount++; if (xA[128] !== 8'd159 || yA[128] !== 7'd111) begin failCount++; $display("[TB] FAIL glyph_i_last: got (%0d,%0d), required (159,111)", xA[128], yA[128]); end
        assertCount++; if (plotN !== mPlotCount()) begin failCount++; $display("[TB] FAIL glyph_i_plot_count: got %0d, required %0d", plotN, mPlotCount()); end
        assertCount++; if (doneA[129] !== 1'b1) begin failCount++; $display("[TB] FAIL glyph_i_done: got %b at cycle 129, required 1", doneA[129]); end
    endtask

    task automatic test_out_of_range();
        int plotN, busyN;
        for (int t = 0; t < 2; t++) begin
            plotN = 0; busyN = 0;
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, (t == 0) ? 20 : 5,
                          (t == 0) ? 0 : 7, 3'($urandom), 3'($urandom));
            captureOutput(10, 1'b0);
            for (int i = 1; i <= 10; i++) begin
                if (plotA[i] === 1'b1) plotN++;
                if (busyA[i] === 1'b1) busyN++;
            end
            assertCount++; if (plotN !== 0) begin failCount++; $display("[TB] FAIL oor%0d_plots: got %0d, required 0", t, plotN); end
            assertCount++; if (doneA[1] !== 1'b1 || doneA[2] !== 1'b0) begin failCount++; $display("[TB] FAIL oor%0d_done: got done[1..2]=%b%b, required 10", t, doneA[1], doneA[2]); end
            assertCount++; if (busyN !== 1 || busyA[1] !== 1'b1) begin failCount++; $display("[TB] FAIL oor%0d_busy: got %0d cycles, required 1", t, busyN); end
        end
    endtask

    task automatic test_back_to_back();
        int plotN = 0;
        int doneN = 0;
        applyStimulus({128{1'b1}}, 3, 2, 3'b101, 3'b010);
        captureOutput(200, 1'b1);
        bus.start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            if (plotA[i] === 1'b1) plotN++;
            if (doneA[i] === 1'b1) doneN++;
        end
        assertCount++; if (plotN !== 198) begin failCount++; $display("[TB] FAIL held_plot_count: got %0d, required 198", plotN); end
        assertCount++; if (doneN !== 1 || doneA[129] !== 1'b1) begin failCount++; $display("[TB] FAIL held_done: got %0d pulses (cycle129=%b), required 1 at 129", doneN, doneA[129]); end
        assertCount++; if (plotA[129] !== 1'b0 || plotA[130] !== 1'b0 || busyA[130] !== 1'b0) begin
            failCount++; $display("[TB] FAIL held_gap: got plot129=%b plot130=%b busy130=%b, required 000", plotA[129], plotA[130], busyA[130]);
        end
        assertCount++; if (plotA[131] !== 1'b1 || xA[131] !== 8'd24 || yA[131] !== 7'd32) begin
            failCount++; $display("[TB] FAIL held_second_start: got plot=%b (%0d,%0d) at cycle 131, required 1 (24,32)", plotA[131], xA[131], yA[131]);
        end
        repeat (70) @(negedge clk);
    endtask

    task automatic test_reset_mid_draw();
        int plotN = 0;
        int doneN = 0;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 19),
                      $urandom_range(0, 6), 3'($urandom), 3'($urandom));
        captureOutput(50, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        assertCount++; if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failCount++; $display("[TB] FAIL midreset_outputs: got plot=%b busy=%b done=%b, required 000", bus.plot, bus.busy, bus.done);
        end
        reset = 1'b0;
        captureOutput(140, 1'b0);
        for (int i = 1; i <= 140; i++) begin
            if (plotA[i] === 1'b1) plotN++;
            if (doneA[i] === 1'b1) doneN++;
        end
        assertCount++; if (plotN !== 0 || doneN !== 0) begin failCount++; $display("[TB] FAIL midreset_quiet: got %0d plots %0d done, required 0 0", plotN, doneN); end
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 19),
                      $urandom_range(0, 6), 3'($urandom), 3'($urandom));
        captureOutput(140, 1'b0);
        for (int k = 0; k < 128; k++) begin
            assertCount++;
            if (plotA[k+1] !== mPlot(k) || (mPlot(k) && (xA[k+1] !== 8'(mX(k)) ||
                yA[k+1] !== 7'(mY(k)) || colourA[k+1] !== mColour(k)))) begin
                failCount++;
                $display("[TB] FAIL midreset_redraw_pixel %0d: got plot=%b x=%0d y=%0d colour=%b, required plot=%b x=%0d y=%0d colour=%b",
                         k, plotA[k+1], xA[k+1], yA[k+1], colourA[k+1], mPlot(k), mX(k), mY(k), mColour(k));
            end
        end
        assertCount++; if (doneA[129] !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_redraw_done: got %b at cycle 129, required 1", doneA[129]); end
    endtask

    task automatic test_random();
        int plotN;
        for (int t = 0; t < 6; t++) begin
            plotN = 0;
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 21),
                          $urandom_range(0, 7), 3'($urandom), 3'($urandom));
            captureOutput(140, 1'b0);
            for (int i = 1; i <= 140; i++) if (plotA[i] === 1'b1) plotN++;
            if (reqCol < 20 && reqRow < 7) begin
                for (int k = 0; k < 128; k++) begin
                    assertCount++;
                    if (plotA[k+1] !== mPlot(k) || (mPlot(k) && (xA[k+1] !== 8'(mX(k)) ||
                        yA[k+1] !== 7'(mY(k)) || colourA[k+1] !== mColour(k)))) begin
                        failCount++;
                        $display("[TB] FAIL random%0d_pixel %0d: got plot=%b x=%0d y=%0d colour=%b, required plot=%b x=%0d y=%0d colour=%b",
                                 t, k, plotA[k+1], xA[k+1], yA[k+1], colourA[k+1], mPlot(k), mX(k), mY(k), mColour(k));
                    end
                end
                assertCount++; if (doneA[129] !== 1'b1) begin failCount++; $display("[TB] FAIL random%0d_done: got %b at cycle 129, required 1", t, doneA[129]); end
            end else begin
                assertCount++; if (plotN !== 0 || doneA[1] !== 1'b1) begin
                    failCount++; $display("[TB] FAIL random%0d_oor: got %0d plots done1=%b, required 0 plots done1=1", t, plotN, doneA[1]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_glyph_i();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_draw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
